// File: rtl/redirect_ctrl.sv
// redirect_ctrl
//   Central flush/redirect sequencer. Arbitrates redirect requests from the ROB
//   (reload), the execution units (branch mispredict) and BPCheck (predecode
//   fix-up). It drives the frontend/backend flush pulses and the aRAT remap
//   window, then hands exactly one redirect PC to the FTQ over valid/ready.
//
//   Sequence per accepted request: IDLE -> FLUSH -> [REMAP, ROB only] -> REDIR -> IDLE.
//   Priority for new requests is ROB > EU > BPC. In any busy state, a ROB
//   request always restarts the sequence. An EU request restarts it only if it
//   beats the held request (held BPC, or held EU with a younger index). BPC
//   requests that arrive while busy are dropped.
//
// Parameters
//   PC_W       redirect PC width
//   ROB_IDX_W  ROB index width (index ports carry one extra wrap MSB)
//   FLUSH_CYC  cycles the flush outputs stay high (>=1)
//   REMAP_CYC  cycles aRATRemapping stays high (>=1)
//
// Ports
//   Clk, Rest                      clock, synchronous active-high reset
//   ROBReload/ROBPc                ROB reload request and restart PC
//   EUMiss/EUPc/EUIdx              branch mispredict request, target, ROB index
//   BPCMiss/BPCPc                  predecode redirect request and fetch PC
//   FTQFlash..DecodeFlash          frontend flush group
//   DispathFlash..EUFlash          backend flush group
//   BackFlushAll/BackFlushIdx      whole-backend flush, or flush younger than index
//   aRATRemapping                  copy aRAT into RAT
//   RedirectValid/Pc/Ready         redirect handshake to the FTQ
//   CtrlBusy                       sequencer not idle
//   PerfRobCnt/PerfEuCnt/PerfBpcCnt  accepted-redirect counters per source
//                                    (only with REDIRECT_PERF_CNT_EN)
//
// Build option
//   REDIRECT_PERF_CNT_EN  adds three 32-bit saturating per-source redirect counters.

module redirect_ctrl #(
   parameter int unsigned PC_W      = 32,
   parameter int unsigned ROB_IDX_W = 6,
   parameter int unsigned FLUSH_CYC = 2,
   parameter int unsigned REMAP_CYC = 1
) (
   input  logic                 Clk,
   input  logic                 Rest,
   input  logic                 ROBReload,
   input  logic [PC_W-1:0]      ROBPc,
   input  logic                 EUMiss,
   input  logic [PC_W-1:0]      EUPc,
   input  logic [ROB_IDX_W:0]   EUIdx,
   input  logic                 BPCMiss,
   input  logic [PC_W-1:0]      BPCPc,
   output logic                 FTQFlash,
   output logic                 BPCheckFlash,
   output logic                 InstQueFlash,
   output logic                 DecodeFlash,
   output logic                 DispathFlash,
   output logic                 AllRSFlash,
   output logic                 EUFlash,
   output logic                 BackFlushAll,
   output logic [ROB_IDX_W:0]   BackFlushIdx,
   output logic                 aRATRemapping,
   output logic                 RedirectValid,
   output logic [PC_W-1:0]      RedirectPc,
   input  logic                 RedirectReady,
`ifdef REDIRECT_PERF_CNT_EN
   output logic [31:0]          PerfRobCnt,
   output logic [31:0]          PerfEuCnt,
   output logic [31:0]          PerfBpcCnt,
`endif
   output logic                 CtrlBusy
);

   localparam int unsigned CntMax = (FLUSH_CYC > REMAP_CYC) ? FLUSH_CYC : REMAP_CYC;
   localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);
   localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_CYC - 1);
   localparam logic [CntW-1:0] RemapLoad = CntW'(REMAP_CYC - 1);

   typedef enum logic [1:0] {StIdle, StFlush, StRemap, StRedir} state_t;
   typedef enum logic [1:0] {SrcNone, SrcRob, SrcEu, SrcBpc} src_t;

   state_t              state, nextState;
   src_t                heldSrc, nextSrc;
   logic [PC_W-1:0]     heldPc, nextPc;
   logic [ROB_IDX_W:0]  heldIdx, nextIdx;
   logic [CntW-1:0]     cnt, nextCnt;

   src_t                reqSrc;
   logic [PC_W-1:0]     reqPc;
   logic [ROB_IDX_W:0]  reqIdx;
   logic                anyReq;
   logic                euPreempt;
   logic                take;

   logic                nextFlush;
   logic                nextBackFlush;

   // a is older than b. Equal wrap bits compare directly; differing wrap
   // bits mean b has wrapped past a, so the ordering of the low bits flips.
   function automatic logic isOlder(input logic [ROB_IDX_W:0] a,
                                    input logic [ROB_IDX_W:0] b);
      if (a[ROB_IDX_W] == b[ROB_IDX_W]) begin
         return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
      end else begin
         return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
      end
   endfunction

   // Fixed-priority pick of the incoming request. This pick is also right
   // while busy: take is only raised for ROB or a preempting EU, and ROB
   // outranks EU.
   always_comb begin
      reqSrc = SrcNone;
      reqPc  = '0;
      reqIdx = '0;
      if (ROBReload) begin
         reqSrc = SrcRob;
         reqPc  = ROBPc;
      end else if (EUMiss) begin
         reqSrc = SrcEu;
         reqPc  = EUPc;
         reqIdx = EUIdx;
      end else if (BPCMiss) begin
         reqSrc = SrcBpc;
         reqPc  = BPCPc;
      end
   end

   assign anyReq    = ROBReload | EUMiss | BPCMiss;
   assign euPreempt = EUMiss && ((heldSrc == SrcBpc) ||
                                 ((heldSrc == SrcEu) && isOlder(EUIdx, heldIdx)));
   assign take      = (state == StIdle) ? anyReq : (ROBReload | euPreempt);

   // Next-state logic. A take, including a preemption, outranks all in-state
   // progress, so a preemption also cancels a handshake in the same cycle.
   always_comb begin
      nextState = state;
      nextSrc   = heldSrc;
      nextPc    = heldPc;
      nextIdx   = heldIdx;
      nextCnt   = cnt;
      if (take) begin
         nextState = StFlush;
         nextSrc   = reqSrc;
         nextPc    = reqPc;
         nextIdx   = reqIdx;
         nextCnt   = FlushLoad;
      end else begin
         unique case (state)
            StIdle: begin
               nextState = StIdle;
            end
            StFlush: begin
               if (cnt == '0) begin
                  if (heldSrc == SrcRob) begin
                     nextState = StRemap;
                     nextCnt   = RemapLoad;
                  end else begin
                     nextState = StRedir;
                  end
               end else begin
                  nextCnt = cnt - CntW'(1);
               end
            end
            StRemap: begin
               if (cnt == '0) begin
                  nextState = StRedir;
               end else begin
                  nextCnt = cnt - CntW'(1);
               end
            end
            StRedir: begin
               if (RedirectValid && RedirectReady) begin
                  nextState = StIdle;
                  nextSrc   = SrcNone;
                  nextPc    = '0;
                  nextIdx   = '0;
               end
            end
            default: begin
               nextState = StIdle;
            end
         endcase
      end
   end

   // Outputs are registered from the next state, so they line up with the
   // state they describe.
   assign nextFlush     = (nextState == StFlush);
   assign nextBackFlush = nextFlush && (nextSrc != SrcBpc);

`ifdef REDIRECT_PERF_CNT_EN
   logic accept;
   assign accept = (state == StRedir) && RedirectValid && RedirectReady && !take;
`endif

   always_ff @(posedge Clk) begin
      if (Rest) begin
         state         <= StIdle;
         heldSrc       <= SrcNone;
         heldPc        <= '0;
         heldIdx       <= '0;
         cnt           <= '0;
         FTQFlash      <= 1'b0;
         BPCheckFlash  <= 1'b0;
         InstQueFlash  <= 1'b0;
         DecodeFlash   <= 1'b0;
         DispathFlash  <= 1'b0;
         AllRSFlash    <= 1'b0;
         EUFlash       <= 1'b0;
         BackFlushAll  <= 1'b0;
         BackFlushIdx  <= '0;
         aRATRemapping <= 1'b0;
         RedirectValid <= 1'b0;
         RedirectPc    <= '0;
         CtrlBusy      <= 1'b0;
`ifdef REDIRECT_PERF_CNT_EN
         PerfRobCnt    <= '0;
         PerfEuCnt     <= '0;
         PerfBpcCnt    <= '0;
`endif
      end else begin
         state         <= nextState;
         heldSrc       <= nextSrc;
         heldPc        <= nextPc;
         heldIdx       <= nextIdx;
         cnt           <= nextCnt;
         FTQFlash      <= nextFlush;
         BPCheckFlash  <= nextFlush;
         InstQueFlash  <= nextFlush;
         DecodeFlash   <= nextFlush;
         DispathFlash  <= nextBackFlush;
         AllRSFlash    <= nextBackFlush;
         EUFlash       <= nextBackFlush;
         BackFlushAll  <= nextBackFlush && (nextSrc == SrcRob);
         BackFlushIdx  <= (nextBackFlush && (nextSrc == SrcEu)) ? nextIdx : '0;
         aRATRemapping <= (nextState == StRemap);
         RedirectValid <= (nextState == StRedir);
         RedirectPc    <= (nextState == StRedir) ? nextPc : '0;
         CtrlBusy      <= (nextState != StIdle);
`ifdef REDIRECT_PERF_CNT_EN
         // Counted only on a handshake that really completes.
         if (accept && (heldSrc == SrcRob) && (PerfRobCnt != '1)) begin
            PerfRobCnt <= PerfRobCnt + 32'd1;
         end
         if (accept && (heldSrc == SrcEu) && (PerfEuCnt != '1)) begin
            PerfEuCnt <= PerfEuCnt + 32'd1;
         end
         if (accept && (heldSrc == SrcBpc) && (PerfBpcCnt != '1)) begin
            PerfBpcCnt <= PerfBpcCnt + 32'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Testbench for redirect_ctrl: directed scenarios followed by random traffic.
// A transaction-level model tracks the held request and the cycles since it
// was latched. Each cycle the model pushes the output vector it expects, and
// it pushes each redirect it expects the FTQ to accept. A monitor on the
// falling edge pops both queues and compares them with the DUT.

module tb_redirect_ctrl;

   localparam int unsigned PC_W      = 32;
   localparam int unsigned ROB_IDX_W = 6;
   localparam int unsigned FLUSH_CYC = 2;
   localparam int unsigned REMAP_CYC = 1;
   localparam int unsigned IdxW      = ROB_IDX_W + 1;
   localparam int unsigned VecW      = 4 + 3 + 1 + IdxW + 1 + 1 + PC_W + 1;

   localparam int SRC_NONE = 0;
   localparam int SRC_ROB  = 1;
   localparam int SRC_EU   = 2;
   localparam int SRC_BPC  = 3;

   logic Clk = 1'b0;
   logic Rest, ROBReload, EUMiss, BPCMiss, RedirectReady;
   logic [PC_W-1:0] ROBPc, EUPc, BPCPc, RedirectPc;
   logic [IdxW-1:0] EUIdx, BackFlushIdx;
   logic FTQFlash, BPCheckFlash, InstQueFlash, DecodeFlash;
   logic DispathFlash, AllRSFlash, EUFlash, BackFlushAll;
   logic aRATRemapping, RedirectValid, CtrlBusy;
`ifdef REDIRECT_PERF_CNT_EN
   logic [31:0] PerfRobCnt, PerfEuCnt, PerfBpcCnt;
`endif

   redirect_ctrl #(
      .PC_W(PC_W), .ROB_IDX_W(ROB_IDX_W), .FLUSH_CYC(FLUSH_CYC), .REMAP_CYC(REMAP_CYC)
   ) dut (
      .Clk(Clk), .Rest(Rest),
      .ROBReload(ROBReload), .ROBPc(ROBPc),
      .EUMiss(EUMiss), .EUPc(EUPc), .EUIdx(EUIdx),
      .BPCMiss(BPCMiss), .BPCPc(BPCPc),
      .FTQFlash(FTQFlash), .BPCheckFlash(BPCheckFlash),
      .InstQueFlash(InstQueFlash), .DecodeFlash(DecodeFlash),
      .DispathFlash(DispathFlash), .AllRSFlash(AllRSFlash), .EUFlash(EUFlash),
      .BackFlushAll(BackFlushAll), .BackFlushIdx(BackFlushIdx),
      .aRATRemapping(aRATRemapping),
      .RedirectValid(RedirectValid), .RedirectPc(RedirectPc),
      .RedirectReady(RedirectReady),
`ifdef REDIRECT_PERF_CNT_EN
      .PerfRobCnt(PerfRobCnt), .PerfEuCnt(PerfEuCnt), .PerfBpcCnt(PerfBpcCnt),
`endif
      .CtrlBusy(CtrlBusy)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [VecW-1:0] v;
      logic [VecW-1:0] m;
   } exp_t;

   typedef struct packed {
      logic [1:0]      src;
      logic [PC_W-1:0] pc;
   } redir_t;

   exp_t   expCycleQ[$];
   redir_t expRedirQ[$];

   int checks   = 0;
   int failures = 0;

   // Reference model state: the held request and the cycles since it was latched.
   bit              mBusy = 1'b0;
   int              mSrc  = SRC_NONE;
   logic [PC_W-1:0] mPc   = '0;
   logic [IdxW-1:0] mIdx  = '0;
   int              mAge  = 0;
   int              cntRob = 0, cntEu = 0, cntBpc = 0;

   function automatic bit idxOlder(input logic [IdxW-1:0] a, input logic [IdxW-1:0] b);
      int la, lb;
      la = int'(a[ROB_IDX_W-1:0]);
      lb = int'(b[ROB_IDX_W-1:0]);
      if (a[ROB_IDX_W] == b[ROB_IDX_W]) return la < lb;
      return la > lb;
   endfunction

   // Cycles from latch until the redirect is offered.
   function automatic int latency(input int src);
      return FLUSH_CYC + ((src == SRC_ROB) ? REMAP_CYC : 0);
   endfunction

   function automatic exp_t modelOut();
      exp_t r;
      bit fl, be, rm, vl, isEu;
      fl   = mBusy && (mAge < FLUSH_CYC);
      be   = fl && (mSrc != SRC_BPC);
      isEu = be && (mSrc == SRC_EU);
      rm   = mBusy && (mSrc == SRC_ROB) && (mAge >= FLUSH_CYC) && (mAge < latency(mSrc));
      vl   = mBusy && (mAge >= latency(mSrc));
      r.v = {fl, fl, fl, fl, be, be, be, (be && (mSrc == SRC_ROB)),
             (isEu ? mIdx : {IdxW{1'b0}}), rm, vl, (vl ? mPc : {PC_W{1'b0}}), mBusy};
      // BackFlushAll/Idx only matter during a backend flush, the PC only when valid.
      r.m = {7'h7F, be, {IdxW{isEu}}, 1'b1, 1'b1, {PC_W{vl}}, 1'b1};
      return r;
   endfunction

   task automatic mLatch(input int src, input logic [PC_W-1:0] pc, input logic [IdxW-1:0] idx);
      mBusy = 1'b1;
      mSrc  = src;
      mPc   = pc;
      mIdx  = (src == SRC_EU) ? idx : '0;
      mAge  = 0;
   endtask

   always @(posedge Clk) begin : model
      bit valid;
      redir_t r;
      valid = mBusy && (mAge >= latency(mSrc));
      if (Rest) begin
         mBusy = 1'b0; mSrc = SRC_NONE; mPc = '0; mIdx = '0; mAge = 0;
      end else if (!mBusy) begin
         if (ROBReload)    mLatch(SRC_ROB, ROBPc, '0);
         else if (EUMiss)  mLatch(SRC_EU, EUPc, EUIdx);
         else if (BPCMiss) mLatch(SRC_BPC, BPCPc, '0);
      end else if (ROBReload) begin
         mLatch(SRC_ROB, ROBPc, '0);
      end else if (EUMiss && ((mSrc == SRC_BPC) || ((mSrc == SRC_EU) && idxOlder(EUIdx, mIdx)))) begin
         mLatch(SRC_EU, EUPc, EUIdx);
      end else if (valid && RedirectReady) begin
         r.src = 2'(mSrc);
         r.pc  = mPc;
         expRedirQ.push_back(r);
         if (mSrc == SRC_ROB) cntRob++;
         else if (mSrc == SRC_EU) cntEu++;
         else cntBpc++;
         mBusy = 1'b0; mSrc = SRC_NONE; mPc = '0; mIdx = '0; mAge = 0;
      end else if (!valid) begin
         mAge++;
      end
      expCycleQ.push_back(modelOut());
   end

   // Monitor. A handshake counts as taken when valid&&ready was seen and the
   // controller is idle one cycle later (preemption keeps it busy).
   bit              hsPend = 1'b0;
   bit              hsRst  = 1'b0;
   logic [PC_W-1:0] hsPc   = '0;

   always @(negedge Clk) begin : monitor
      exp_t e;
      redir_t r;
      logic [VecW-1:0] a;
      a = {FTQFlash, BPCheckFlash, InstQueFlash, DecodeFlash, DispathFlash, AllRSFlash,
           EUFlash, BackFlushAll, BackFlushIdx, aRATRemapping, RedirectValid, RedirectPc,
           CtrlBusy};
      checks++;
      if (expCycleQ.size() == 0) begin
         failures++;
         $display("FAIL cycle_queue @%0t got=empty_queue required=an_expected_entry", $time);
      end else begin
         e = expCycleQ.pop_front();
         if ((a & e.m) !== (e.v & e.m)) begin
            failures++;
            $display("FAIL outputs @%0t got=%h required=%h", $time, a & e.m, e.v & e.m);
         end
      end
      if (hsPend && !hsRst && !CtrlBusy) begin
         checks++;
         if (expRedirQ.size() == 0) begin
            failures++;
            $display("FAIL redirect @%0t got=pc_%h required=no_redirect", $time, hsPc);
         end else begin
            r = expRedirQ.pop_front();
            if (hsPc !== r.pc) begin
               failures++;
               $display("FAIL redirect @%0t got=pc_%h required=pc_%h(src%0d)",
                        $time, hsPc, r.pc, r.src);
            end
         end
      end
      hsPend = RedirectValid && RedirectReady;
      hsPc   = RedirectPc;
      hsRst  = Rest;
   end

   // Drive one cycle of inputs, then advance past the next rising edge.
   task automatic drive(input bit rob, input logic [PC_W-1:0] robPc,
                        input bit eu, input logic [PC_W-1:0] euPc, input logic [IdxW-1:0] euIdx,
                        input bit bpc, input logic [PC_W-1:0] bpcPc,
                        input bit rdy, input bit rst);
      ROBReload = rob; ROBPc = robPc;
      EUMiss = eu; EUPc = euPc; EUIdx = euIdx;
      BPCMiss = bpc; BPCPc = bpcPc;
      RedirectReady = rdy; Rest = rst;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) drive(0, '0, 0, '0, '0, 0, '0, rdy, 0);
   endtask

   initial begin
      Rest = 1'b1; ROBReload = 0; EUMiss = 0; BPCMiss = 0; RedirectReady = 0;
      ROBPc = '0; EUPc = '0; EUIdx = '0; BPCPc = '0;
      drive(0, '0, 0, '0, '0, 0, '0, 0, 1);
      drive(0, '0, 0, '0, '0, 0, '0, 0, 1);

      // EU mispredict from idle.
      drive(0, '0, 1, 32'h1C00_0100, 7'h05, 0, '0, 1, 0);
      idle(5, 1);

      // ROB and BPC in the same cycle: ROB wins, BPC is dropped.
      drive(1, 32'h1C00_8000, 0, '0, '0, 1, 32'h1C00_BEEF, 1, 0);
      idle(6, 1);

      // Age rule: a younger index is ignored, an older one preempts.
      drive(0, '0, 1, 32'h1C00_0A00, 7'h3E, 0, '0, 0, 0);
      drive(0, '0, 1, 32'h1C00_0B00, 7'h42, 0, '0, 0, 0);
      idle(1, 0);
      drive(0, '0, 1, 32'h1C00_0C00, 7'h3A, 0, '0, 0, 0);
      idle(4, 0);
      idle(3, 1);

      // Redirect stalls on ready low, then a ROB reload preempts it.
      drive(0, '0, 0, '0, '0, 1, 32'h1C00_0D00, 0, 0);
      idle(4, 0);
      drive(1, 32'h1C00_0E00, 0, '0, '0, 0, '0, 0, 0);
      idle(2, 0);
      idle(5, 1);

      // Reset during REMAP, then a BPC redirect flushes the frontend only.
      drive(1, 32'h1C00_0F00, 0, '0, '0, 0, '0, 1, 0);
      idle(2, 1);
      drive(0, '0, 0, '0, '0, 0, '0, 1, 1);
      drive(0, '0, 0, '0, '0, 1, 32'h1C00_1000, 1, 0);
      idle(4, 1);

      // Mix for the counters: 3 EU redirects, then a BPC preempted by ROB, then ROB.
      for (int k = 0; k < 3; k++) begin
         drive(0, '0, 1, 32'h1C00_2000 + 32'(k * 4), 7'(k), 0, '0, 1, 0);
         idle(4, 1);
      end
      drive(0, '0, 0, '0, '0, 1, 32'h1C00_3000, 1, 0);
      drive(1, 32'h1C00_3100, 0, '0, '0, 0, '0, 1, 0);
      idle(5, 1);
      drive(1, 32'h1C00_3200, 0, '0, '0, 0, '0, 1, 0);
      idle(5, 1);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(99) < 4, $urandom,
               $urandom_range(99) < 12, $urandom, 7'($urandom),
               $urandom_range(99) < 12, $urandom,
               $urandom_range(99) < 70, $urandom_range(199) == 0);
      end

      // Drain.
      idle(10, 1);
      @(negedge Clk);
      #1;
      checks++;
      if (expRedirQ.size() != 0) begin
         failures++;
         $display("FAIL redirect_drain got=%0d_pending required=0_pending", expRedirQ.size());
      end
`ifdef REDIRECT_PERF_CNT_EN
      checks++;
      if (PerfRobCnt !== 32'(cntRob) || PerfEuCnt !== 32'(cntEu) || PerfBpcCnt !== 32'(cntBpc)) begin
         failures++;
         $display("FAIL perf_counters got=%0d/%0d/%0d required=%0d/%0d/%0d",
                  PerfRobCnt, PerfEuCnt, PerfBpcCnt, cntRob, cntEu, cntBpc);
      end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Central flush/redirect sequencer between the redirect sources (ROB reload, EU branch mispredict, BPCheck predecode fix-up) and the pipeline stages. It arbitrates among simultaneous and overlapping redirect requests. It sequences the flush pulses for the frontend and backend groups and the aRAT remap window. It then hands exactly one redirect PC to the FTQ through a valid/ready handshake.

## Interface
- `PC_W`, 32, redirect PC width
- `ROB_IDX_W`, 6, ROB index width; every index port carries one extra MSB wrap bit
- `FLUSH_CYC`, 2, cycles the flush outputs stay high (≥1)
- `REMAP_CYC`, 1, cycles `aRATRemapping` stays high (≥1)

- `Clk` in 1: sole clock, rising edge
- `Rest` in 1: synchronous, active-high reset
- `ROBReload` in 1: ROB exception/reload pulse, one cycle
- `ROBPc` in PC_W: restart PC, valid with `ROBReload`
- `EUMiss` in 1: branch-mispredict pulse, one cycle
- `EUPc` in PC_W: corrected target
- `EUIdx` in ROB_IDX_W+1: ROB index of the mispredicted branch
- `BPCMiss` in 1: predecode redirect pulse, one cycle
- `BPCPc` in PC_W: corrected fetch PC
- `FTQFlash`, `BPCheckFlash`, `InstQueFlash`, `DecodeFlash` out 1: frontend flush group
- `DispathFlash`, `AllRSFlash`, `EUFlash` out 1: backend flush group
- `BackFlushAll` out 1: 1 = flush the whole backend; 0 = flush entries younger than `BackFlushIdx`
- `BackFlushIdx` out ROB_IDX_W+1: flush boundary index
- `aRATRemapping` out 1: copy aRAT into RAT
- `RedirectValid` out 1 / `RedirectPc` out PC_W / `RedirectReady` in 1: handshake to the FTQ
- `CtrlBusy` out 1: high when state ≠ IDLE

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE and the held request is cleared.
- The held request consists of src ∈ {ROB, EU, BPC}, pc, and idx.
- **IDLE**: on any request, latch the winner by priority ROB > EU > BPC, load `cnt = FLUSH_CYC-1`, and go to FLUSH. Losing requests in the same cycle are dropped.
- **FLUSH**: flush outputs are high. Decrement `cnt`. At `cnt==0`:
  - if src=ROB, go to REMAP with `cnt = REMAP_CYC-1`;
  - otherwise go to REDIR.
- **REMAP**: `aRATRemapping` is high. At `cnt==0`, go to REDIR.
- **REDIR**: `RedirectValid` is high and `RedirectPc` holds pc. When `RedirectValid && RedirectReady`, go to IDLE.
- Flush groups by src:
  - BPC: frontend group only.
  - EU: both groups, with `BackFlushAll=0` and `BackFlushIdx=idx`.
  - ROB: both groups, with `BackFlushAll=1`.
- Preemption applies in FLUSH, REMAP or REDIR. A preempting request relatches and restarts FLUSH with a full count, and `RedirectValid` drops.
  - `ROBReload` always preempts, including over a held ROB request; the newest ROB request wins.
  - `EUMiss` preempts when the held src is BPC, or when the held src is EU and `EUIdx` is older than the held idx.
  - `BPCMiss` never preempts; it is dropped.
- Age rule: a is older than b if `a[MSB]==b[MSB] ? a[low]<b[low] : a[low]>b[low]`. Equal indices are not older.
- Simultaneous requests during a busy state: only the highest-priority preempting request is evaluated.
- A completing handshake in the same cycle as a preempting request: the preemption wins and the handshake counts as not taken.
- Reset mid-operation: all outputs are 0 on the next edge and the held request is lost.

## Timing
- Request sampled at edge t → flush outputs high for cycles t+1 … t+FLUSH_CYC.
- ROB src: `aRATRemapping` is high for the next REMAP_CYC cycles.
- `RedirectValid` first rises in the cycle after the last flush or remap cycle, and holds until accepted.
- With `RedirectReady` tied high, latency from request to handshake is FLUSH_CYC+1 cycles (EU/BPC) or FLUSH_CYC+REMAP_CYC+1 cycles (ROB).
- `CtrlBusy` goes high at t+1 and low in the cycle after the handshake.

## Configuration
- `REDIRECT_PERF_CNT_EN` defined: adds three 32-bit saturating counters, counting redirects taken per source (ROB, EU, BPC). A redirect is counted at handshake acceptance; preempted requests are not counted. The counters are exposed as outputs `PerfRobCnt`, `PerfEuCnt` and `PerfBpcCnt`, and reset to 0.
- Undefined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Idle `EUMiss`, `EUIdx=0x05`, `EUPc=0x1C000100`, ready high → both flush groups high 2 cycles, `BackFlushAll=0`, `BackFlushIdx=0x05`; `RedirectPc=0x1C000100` accepted at cycle 3; no remap.
- Same cycle `ROBReload` (`ROBPc=0x1C008000`) + `BPCMiss` → ROB wins; flush 2 cycles, `aRATRemapping` 1 cycle, then one redirect to 0x1C008000; the BPC request never appears.
- Held EU idx=0x3E (wrap 0), then `EUMiss` idx=0x42 (wrap 1, younger) → ignored; then `EUMiss` idx=0x3A → preempts, flush restarts with `BackFlushIdx=0x3A`.
- REDIR with ready low for 5 cycles → `RedirectValid` held, `RedirectPc` stable; `ROBReload` in cycle 3 → valid drops, FLUSH restarts, final redirect is the ROB PC.
- Assert `Rest` during REMAP → next cycle all outputs 0, `CtrlBusy=0`; a subsequent `BPCMiss` → frontend flush only, backend flush signals stay 0.
- With `REDIRECT_PERF_CNT_EN`: 3 EU, 1 preempted BPC, 2 ROB redirects → counts EU=3, BPC=0, ROB=2.
